go_dispatch: RTL
================

Name: go_dispatch

Overview:
Upstream launcher for the three-channel go/kill/done delay block. Accepts channel-tagged requests on a valid/ready handshake and issues a one-cycle go pulse to the addressed channel. Waits for that channel's done, with a per-channel watchdog. On timeout, issues a one-cycle kill pulse and records a sticky error.

Parameters:
TMO_W, 8, width of each per-channel watchdog counter
TMO_CYCLES, 200, WAIT cycles allowed before kill; legal range 1..2**TMO_W-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_chan  input  2  target channel: 0,1,2 = channel 1,2,3; 3 = illegal
req_ready  output  1  request accepted this cycle when high with req_valid
go_1, go_2, go_3  output  1 each  one-cycle launch pulse per channel
kill_1, kill_2, kill_3  output  1 each  one-cycle abort pulse per channel
done_1, done_2, done_3  input  1 each  completion from the downstream channels
busy  output  3  bit i high while channel i+1 is not IDLE
tmo_err  output  3  sticky per-channel timeout flag
ill_err  output  1  sticky flag: request with req_chan==3 was accepted
err_clr  input  1  synchronous clear of tmo_err and ill_err

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high on port reset. All state and outputs reset to 0; every channel resets to IDLE.
- Outputs: all registered except req_ready, which is combinational.
- req_ready:
  - High when req_chan==3.
  - High when req_chan selects a channel that is in IDLE.
  - Low otherwise.
  - Independent of req_valid.
- Accept = req_valid && req_ready.
  - Illegal channel: accepted and dropped; ill_err set on the next edge.
- Per-channel FSM states: IDLE, ISSUE, WAIT, KILL.
  - IDLE: on accept for this channel, go to ISSUE and clear the counter.
  - ISSUE: go_x=1 for exactly this cycle, then go to WAIT.
  - WAIT: counter increments each cycle.
    - done_x=1: go to IDLE.
    - else if counter==TMO_CYCLES-1: go to KILL.
  - KILL: kill_x=1 for exactly this cycle, then go to IDLE; tmo_err[x] set on the same edge.
- Latency:
  - Accept at edge N gives go_x high in cycle N+1.
  - WAIT starts in cycle N+2.
  - With no done, kill_x is high in cycle N+2+TMO_CYCLES.
  - busy is high from cycle N+1 until the cycle the channel returns to IDLE.
- Next request: a channel re-enters IDLE on the edge ending WAIT or KILL, and can accept a new request in that following cycle.
- done_x handling:
  - Ignored in IDLE, ISSUE and KILL; it never sets an error.
  - done_x and timeout in the same WAIT cycle: done wins, no kill, no error.
- Error flags:
  - err_clr and a new error on the same edge: clear wins.
  - Flags never self-clear.
- Independence: channels run concurrently. Only one request is accepted per cycle; there is no arbitration because the interface carries one request per cycle.
- Mid-operation reset: returns all channels to IDLE immediately. Any go or kill pulse in flight is truncated and is not re-issued.
- Counter: TMO_W bits, saturating, never wraps. A TMO_CYCLES value outside the legal range is a configuration error, checked by a simulation assertion.

Optional Feature:
RETRY_EN
- Defined:
  - Each channel has a retry bit, cleared on accept.
  - First timeout: KILL, then ISSUE (go re-issued in the cycle after kill), counter cleared, retry bit set; no error recorded.
  - Second timeout: KILL, then IDLE, and tmo_err[x] set.
  - busy stays high throughout.
- Undefined: first timeout goes KILL, then IDLE, with the error set. No retry bit is synthesised.

Decomposition:
- Package go_dispatch_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, KILL; 2-bit encoding);
  - constant NUM_CH=3;
  - constant CH_ILLEGAL=2'd3.
- Sub-module go_dispatch_chan holds one channel's FSM, counter and optional retry bit, and is instantiated three times.
  - Ports: start, done, go, kill, busy, tmo_pulse.
- Top level holds req_ready decode and the sticky error registers.

Test Plan (TMO_CYCLES=4 unless stated):
- Basic launch: accept chan 1 at edge 0 -> go_2 high in cycle 1 only; busy=3'b010. done_2 in cycle 3 -> busy=0 in cycle 4, no kill, tmo_err=0.
- Timeout: accept chan 0, never assert done_1 -> kill_1 high in cycle 6 only; tmo_err=3'b001 from cycle 7. err_clr plus a chan 2 timeout on the same edge -> tmo_err=0 after that edge.
- Race: done_3 asserted in the 4th WAIT cycle -> kill_3 stays 0 and tmo_err[2] stays 0.
- Backpressure and concurrency:
  - chan 0 busy, request chan 0 -> req_ready=0 and the request is held.
  - Request chan 1 in the same state -> accepted; both channels run concurrently.
  - Request chan 3 -> accepted; ill_err=1, no go pulse.
- Reset mid-WAIT: assert reset while chan 2 is in WAIT -> all outputs 0 immediately. After release, no kill and no error.
- RETRY_EN: no done -> go, kill, go, kill sequence; tmo_err set only after the second kill. Without RETRY_EN -> one kill, error set.

Source files
------------

// File: rtl/go_dispatch_pkg.sv
// go_dispatch_pkg: shared types and constants for the go/kill/done launcher.
package go_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_KILL  = 2'd3
    } state_t;

    localparam int         NUM_CH     = 3;
    localparam logic [1:0] CH_ILLEGAL = 2'd3;

endpackage

// File: rtl/go_dispatch_chan.sv
// go_dispatch_chan: one channel's IDLE/ISSUE/WAIT/KILL sequencer with watchdog.
// Optional macro RETRY_EN: first timeout re-issues go once before flagging.
module go_dispatch_chan
    import go_dispatch_pkg::*;
#(
    parameter int TMO_W      = 8,
    parameter int TMO_CYCLES = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic done,
    output logic go,
    output logic kill,
    output logic busy,
    output logic tmo_pulse
);

    localparam logic [TMO_W-1:0] CNT_LAST = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] CNT_ZERO = {TMO_W{1'b0}};

    state_t           r_state;
    state_t           w_next;
    logic [TMO_W-1:0] r_cnt;
    logic [TMO_W-1:0] w_cnt_next;
    logic             w_final;
    logic             r_go;
    logic             r_kill;
    logic             r_busy;
    logic             r_tmo;
`ifdef RETRY_EN
    logic             r_retry;
    logic             w_retry_next;
`endif

    // Next-state, counter and retry decode; w_final marks a kill that ends the job.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_final    = 1'b1;
`ifdef RETRY_EN
        w_retry_next = r_retry;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next     = ST_ISSUE;
                    w_cnt_next = CNT_ZERO;
`ifdef RETRY_EN
                    w_retry_next = 1'b0;
`endif
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt != CNT_MAX) begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end else begin
                    w_cnt_next = r_cnt;
                end
                // done has priority over a coincident timeout
                if (done) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = ST_KILL;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_KILL: begin
`ifdef RETRY_EN
                if (!r_retry) begin
                    w_next       = ST_ISSUE;
                    w_cnt_next   = CNT_ZERO;
                    w_retry_next = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
`else
                w_next = ST_IDLE;
`endif
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
`ifdef RETRY_EN
        w_final = w_retry_next;
`endif
    end

    // State, counter and registered pulse outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_go    <= 1'b0;
            r_kill  <= 1'b0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_go    <= (w_next == ST_ISSUE);
            r_kill  <= (w_next == ST_KILL);
            r_busy  <= (w_next != ST_IDLE);
            r_tmo   <= (w_next == ST_KILL) && w_final;
        end
    end

`ifdef RETRY_EN
    // Retry bit: remembers that this job has already been re-issued once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retry <= 1'b0;
        end else begin
            r_retry <= w_retry_next;
        end
    end
`endif

    assign go        = r_go;
    assign kill      = r_kill;
    assign busy      = r_busy;
    assign tmo_pulse = r_tmo;

endmodule

// File: rtl/go_dispatch_chk.sv
// go_dispatch_chk: configuration checks for go_dispatch (simulation only effect).
module go_dispatch_chk #(
    parameter int TMO_W      = 8,
    parameter int TMO_CYCLES = 200
) (
    input logic clk,
    input logic reset
);

    // Watchdog limit must fit the counter and allow at least one WAIT cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (TMO_CYCLES >= 1 && TMO_CYCLES <= ((1 << TMO_W) - 1));
        end
    end

endmodule

// File: rtl/go_dispatch.sv
// go_dispatch: request decode, three channel sequencers and sticky error flags.
// Optional macro RETRY_EN enables one automatic re-issue per job on timeout.
module go_dispatch
    import go_dispatch_pkg::*;
#(
    parameter int TMO_W      = 8,
    parameter int TMO_CYCLES = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_chan,
    output logic       req_ready,
    output logic       go_1,
    output logic       go_2,
    output logic       go_3,
    output logic       kill_1,
    output logic       kill_2,
    output logic       kill_3,
    input  logic       done_1,
    input  logic       done_2,
    input  logic       done_3,
    output logic [2:0] busy,
    output logic [2:0] tmo_err,
    output logic       ill_err,
    input  logic       err_clr
);

    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_done;
    logic [NUM_CH-1:0] w_go;
    logic [NUM_CH-1:0] w_kill;
    logic [NUM_CH-1:0] w_busy;
    logic [NUM_CH-1:0] w_tmo;
    logic              w_ready;
    logic              w_accept;
    logic [2:0]        r_tmo_err;
    logic              r_ill_err;

    assign w_done = {done_3, done_2, done_1};

    // Ready decode: illegal channel always drains, otherwise the target must be idle.
    always_comb begin
        w_ready = 1'b0;
        case (req_chan)
            2'd0:       w_ready = !w_busy[0];
            2'd1:       w_ready = !w_busy[1];
            2'd2:       w_ready = !w_busy[2];
            CH_ILLEGAL: w_ready = 1'b1;
            default:    w_ready = 1'b0;
        endcase
    end

    assign w_accept = req_valid && w_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_start[g] = w_accept && (req_chan == 2'(g));

        go_dispatch_chan #(
            .TMO_W      (TMO_W),
            .TMO_CYCLES (TMO_CYCLES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .start     (w_start[g]),
            .done      (w_done[g]),
            .go        (w_go[g]),
            .kill      (w_kill[g]),
            .busy      (w_busy[g]),
            .tmo_pulse (w_tmo[g])
        );
    end

    // Sticky error flags; a clear on the same edge as a new error wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_err <= 3'b000;
            r_ill_err <= 1'b0;
        end else if (err_clr) begin
            r_tmo_err <= 3'b000;
            r_ill_err <= 1'b0;
        end else begin
            r_tmo_err <= r_tmo_err | w_tmo;
            r_ill_err <= r_ill_err | (w_accept && (req_chan == CH_ILLEGAL));
        end
    end

    go_dispatch_chk #(
        .TMO_W      (TMO_W),
        .TMO_CYCLES (TMO_CYCLES)
    ) u_chk (
        .clk   (clk),
        .reset (reset)
    );

    assign req_ready = w_ready;
    assign go_1      = w_go[0];
    assign go_2      = w_go[1];
    assign go_3      = w_go[2];
    assign kill_1    = w_kill[0];
    assign kill_2    = w_kill[1];
    assign kill_3    = w_kill[2];
    assign busy      = w_busy;
    assign tmo_err   = r_tmo_err;
    assign ill_err   = r_ill_err;

endmodule
